speed_encoder: RTL and testbench
================================

# speed_encoder

Quadrature encoder emulator. It turns a 16-bit speed word and a direction bit into a two-phase A/B quadrature pulse train, for driving motor-feedback inputs (HET pins) from a register written over the external memory bus. It sits beside the bus-slave register file in the 25 MHz `clk` domain: `sq` comes from a RAM/register word, and `A`/`B` drive output pins directly.

## Interface

Parameters:
- `PRESCALE`, default 1: number of `clk` cycles per speed tick; legal range is 1 or more.
- `SQ_W`, default 16: width of the speed word.
- `POS_W`, default 32: width of the position counter.

Ports:
- `clk`, in, 1: system clock, 25 MHz nominal.
- `rst`, in, 1: reset, asynchronous, active-low.
- `sq`, in, `SQ_W`: step period in ticks; 0 means stopped.
- `dir`, in, 1: direction; 0 is forward (A leads B), 1 is reverse.
- `A`, out, 1: quadrature phase A.
- `B`, out, 1: quadrature phase B.
- `step`, out, 1: one-cycle pulse on every A/B state change.
- `moving`, out, 1: high while the latched period is nonzero.
- `pos`, out, `POS_W`: signed step count (see Configuration).

## Operation

- Prescaler:
  - Counts 0 to `PRESCALE`-1 and asserts an internal `tick` on its terminal count.
  - `PRESCALE`=1 means `tick` is high every cycle.
- Latched period `sq_l`:
  - Loaded from `sq` at every step boundary.
  - Also loaded on any `tick` while `sq_l`==0.
  - A change on `sq` mid-period takes effect only at the next boundary.
- Period counter `pcnt`:
  - Advances on `tick` and runs 0 to `sq_l`-1.
  - On the `tick` where `pcnt`==`sq_l`-1, a step boundary occurs and `pcnt` is cleared.
- Quadrature state `AB` is a 2-bit Gray sequence:
  - Forward: 00 → 10 → 11 → 01 → 00.
  - Reverse: 00 → 01 → 11 → 10 → 00.
  - One transition per step boundary; exactly one of A or B toggles per step.
- `dir` is sampled only at step boundaries. A direction reversal reverses from the current state, with no extra or skipped state.
- Stopped (`sq_l`==0):
  - `pcnt` is held at 0.
  - `A`/`B` hold their last value.
  - `step`=0 and `moving`=0.
- `A` and `B` are driven from flops, never from combinational decode.

## Timing

- Reset values:
  - `A`=0, `B`=0, `step`=0, `moving`=0, `pos`=0.
  - `sq_l`=0, `pcnt`=0, prescaler=0.
- Reset is asynchronous assert and synchronous-style release. The first tick occurs `PRESCALE` cycles after release.
- Start from stopped, with `PRESCALE`=1:
  - `sq` is latched on the first edge.
  - The first A/B change occurs `sq` edges later.
  - After that, one change every `sq` cycles.
- Period formula: time between A/B changes = `sq_l`×`PRESCALE` clk cycles. The full electrical cycle is 4× that.
- `sq`=1 with `PRESCALE`=1 gives an A/B change on every clk edge, which is the maximum rate.
- `step` is high in the same cycle the new `AB` value appears.
- `moving` updates in the cycle `sq_l` is loaded.
- Setting `sq` to 0 mid-period: the current period still completes and produces its step, then motion stops.

## Configuration

- `SPEED_POS_COUNTER_EN` defined:
  - `pos` is a signed `POS_W` up/down counter.
  - It is +1 on each forward step and −1 on each reverse step, updated with the same edge as `AB`.
  - It wraps modulo 2^`POS_W`.
- `SPEED_POS_COUNTER_EN` not defined:
  - No counter logic is built.
  - `pos` is tied to 0.

## Test plan

- Reset: assert `rst`=0 asynchronously mid-run → `A`=`B`=0, `step`=0, `pos`=0 immediately, without waiting for a clock edge.
- Forward: `PRESCALE`=1, `sq`=4, `dir`=0 → AB 00,10,11,01,00 with changes every 4 cycles; `step` pulses 4 cycles apart; `pos`=4 after 4 steps (macro defined).
- Reverse and reversal: `sq`=2, 3 forward steps, then `dir`=1 → next states 11,10,00; `pos` goes 3,2,1,0.
- Stop and restart: `sq`=5 running, then `sq`=0 → one more step, then AB frozen and `moving`=0. Setting `sq`=3 then gives first change 3 cycles after latch.
- Period change mid-period: `sq` changed 8→2 at `pcnt`=3 → the current step lands at cycle 8, and subsequent steps come every 2 cycles.
- Prescale: `PRESCALE`=4, `sq`=3 → A/B change every 12 cycles; with the macro undefined, `pos` stays 0.

Source files
------------

// File: rtl/speed_encoder_if.sv
// speed_encoder_if: groups the speed-encoder control and pin signals.
//   sq     : step period in ticks (0 = stopped), driven by the register side
//   dir    : direction, 0 = forward (A leads B), 1 = reverse
//   A, B   : quadrature phases
//   step   : one-cycle pulse on every A/B change
//   moving : latched period is nonzero
//   pos    : signed step count (zero unless the position counter is built)
// Modports: master = register side / bench, slave = encoder.
interface speed_encoder_if #(
    parameter int unsigned SQ_W  = 16,
    parameter int unsigned POS_W = 32
);
    logic [SQ_W-1:0]  sq;
    logic             dir;
    logic             A;
    logic             B;
    logic             step;
    logic             moving;
    logic [POS_W-1:0] pos;

    modport master (
        output sq,
        output dir,
        input  A,
        input  B,
        input  step,
        input  moving,
        input  pos
    );

    modport slave (
        input  sq,
        input  dir,
        output A,
        output B,
        output step,
        output moving,
        output pos
    );
endinterface

// File: rtl/speed_encoder.sv
// speed_encoder: quadrature encoder emulator. Turns a step period (in prescaled
// ticks) and a direction bit into an A/B Gray-code pulse train.
// Ports:
//   clk : system clock
//   rst : asynchronous active-low reset
//   bus : speed_encoder_if.slave (sq, dir in; A, B, step, moving, pos out)
// Optional feature: define SPEED_POS_COUNTER_EN to build the signed up/down
// position counter on bus.pos; otherwise bus.pos is tied to zero.
module speed_encoder #(
    parameter int unsigned PRESCALE = 1,
    parameter int unsigned SQ_W     = 16,
    parameter int unsigned POS_W    = 32
) (
    input logic            clk,
    input logic            rst,
    speed_encoder_if.slave bus
);
    localparam int unsigned PresW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PresW-1:0] PresMax = PresW'(PRESCALE - 1);

    logic [PresW-1:0] presc_q, presc_d;
    logic [SQ_W-1:0]  sq_l_q, sq_l_d;
    logic [SQ_W-1:0]  pcnt_q, pcnt_d;
    logic             a_q, a_d;
    logic             b_q, b_d;
    logic             step_q, step_d;
    logic             tick;
    logic             boundary;

    always_comb begin
        tick     = (presc_q == PresMax);
        presc_d  = tick ? '0 : presc_q + PresW'(1);
        boundary = tick && (sq_l_q != '0) && (pcnt_q == sq_l_q - SQ_W'(1));

        sq_l_d = sq_l_q;
        pcnt_d = pcnt_q;
        a_d    = a_q;
        b_d    = b_q;
        step_d = 1'b0;

        if (tick) begin
            if (sq_l_q == '0) begin
                // Stopped: keep polling sq so motion can restart.
                sq_l_d = bus.sq;
                pcnt_d = '0;
            end else if (boundary) begin
                sq_l_d = bus.sq;
                pcnt_d = '0;
                step_d = 1'b1;
                // Gray step: forward 00>10>11>01, reverse runs it backwards.
                if (bus.dir) begin
                    a_d = b_q;
                    b_d = ~a_q;
                end else begin
                    a_d = ~b_q;
                    b_d = a_q;
                end
            end else begin
                pcnt_d = pcnt_q + SQ_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q <= '0;
            sq_l_q  <= '0;
            pcnt_q  <= '0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            step_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            sq_l_q  <= sq_l_d;
            pcnt_q  <= pcnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            step_q  <= step_d;
        end
    end

    assign bus.A      = a_q;
    assign bus.B      = b_q;
    assign bus.step   = step_q;
    assign bus.moving = (sq_l_q != '0);

`ifdef SPEED_POS_COUNTER_EN
    logic [POS_W-1:0] pos_q, pos_d;

    always_comb begin
        pos_d = pos_q;
        if (boundary) begin
            pos_d = bus.dir ? pos_q - POS_W'(1) : pos_q + POS_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pos_q <= '0;
        end else begin
            pos_q <= pos_d;
        end
    end

    assign bus.pos = pos_q;
`else
    assign bus.pos = '0;
`endif
endmodule

// File: tb/tb_speed_encoder.sv
// Bench for speed_encoder: two instances (PRESCALE 1 and 4) share random and
// directed sq/dir stimulus and are compared every cycle against a
// deadline-based model (next step due at latch time + period x prescale).
module tb_speed_encoder;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] sq  = '0;
    logic        dir = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    speed_encoder_if #(.SQ_W(16), .POS_W(32)) if1 ();
    speed_encoder_if #(.SQ_W(16), .POS_W(32)) if4 ();

    assign if1.sq  = sq;
    assign if1.dir = dir;
    assign if4.sq  = sq;
    assign if4.dir = dir;

    speed_encoder #(.PRESCALE(1), .SQ_W(16), .POS_W(32)) u_dut_p1 (
        .clk (clk),
        .rst (rst),
        .bus (if1.slave)
    );

    speed_encoder #(.PRESCALE(4), .SQ_W(16), .POS_W(32)) u_dut_p4 (
        .clk (clk),
        .rst (rst),
        .bus (if4.slave)
    );

    always #5 clk = ~clk;

    // Reference model state, index 0 = PRESCALE 1, index 1 = PRESCALE 4.
    int unsigned pre_m  [2];
    int unsigned per_m  [2];
    longint      due_m  [2];
    logic [1:0]  ph_m   [2];
    logic [31:0] pos_m  [2];
    logic        step_m [2];
    logic [1:0]  ab_tab [4];
    longint      cyc;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        cyc = 0;
        for (int k = 0; k < 2; k++) begin
            per_m[k]  = 0;
            due_m[k]  = 0;
            ph_m[k]   = 2'd0;
            pos_m[k]  = '0;
            step_m[k] = 1'b0;
        end
    endtask

    task automatic model_edge();
        cyc++;
        for (int k = 0; k < 2; k++) begin
            step_m[k] = 1'b0;
            if (cyc % longint'(pre_m[k]) == 0) begin
                if (per_m[k] == 0) begin
                    per_m[k] = sq;
                    if (sq != 0) due_m[k] = cyc + longint'(sq) * longint'(pre_m[k]);
                end else if (cyc == due_m[k]) begin
                    step_m[k] = 1'b1;
                    ph_m[k]   = dir ? ph_m[k] - 2'd1 : ph_m[k] + 2'd1;
                    pos_m[k]  = dir ? pos_m[k] - 32'd1 : pos_m[k] + 32'd1;
                    per_m[k]  = sq;
                    if (sq != 0) due_m[k] = cyc + longint'(sq) * longint'(pre_m[k]);
                end
            end
        end
    endtask

    task automatic check_inst(input int k, input logic a, input logic b, input logic st,
                              input logic mv, input logic [31:0] pos);
        logic [31:0] exp_pos;
`ifdef SPEED_POS_COUNTER_EN
        exp_pos = pos_m[k];
`else
        exp_pos = '0;
`endif
        check_eq($sformatf("p%0d_ab", pre_m[k]), 64'({a, b}), 64'(ab_tab[ph_m[k]]));
        check_eq($sformatf("p%0d_step", pre_m[k]), 64'(st), 64'(step_m[k]));
        check_eq($sformatf("p%0d_moving", pre_m[k]), 64'(mv), 64'(per_m[k] != 0));
        check_eq($sformatf("p%0d_pos", pre_m[k]), 64'(pos), 64'(exp_pos));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_inst(0, if1.A, if1.B, if1.step, if1.moving, if1.pos);
        check_inst(1, if4.A, if4.B, if4.step, if4.moving, if4.pos);
    endtask

    task automatic run(input int n, input logic [15:0] sqv, input logic dirv);
        sq  = sqv;
        dir = dirv;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_p1"}, 64'({if1.A, if1.B, if1.step, if1.moving, if1.pos}), 64'd0);
        check_eq({tag, "_p4"}, 64'({if4.A, if4.B, if4.step, if4.moving, if4.pos}), 64'd0);
    endtask

    initial begin
        pre_m[0]  = 1;
        pre_m[1]  = 4;
        ab_tab[0] = 2'b00;
        ab_tab[1] = 2'b10;
        ab_tab[2] = 2'b11;
        ab_tab[3] = 2'b01;
        model_reset();

        repeat (3) @(negedge clk);
        check_zero("reset_hold");
        rst = 1'b1;

        // Forward, then reversal, stop/restart and a mid-period slow-to-fast change.
        run(40, 16'd4, 1'b0);
        run(7, 16'd2, 1'b0);
        run(14, 16'd2, 1'b1);
        run(30, 16'd5, 1'b0);
        run(40, 16'd0, 1'b0);
        run(40, 16'd3, 1'b0);
        run(20, 16'd1, 1'b1);
        run(4, 16'd8, 1'b0);
        run(4, 16'd8, 1'b0);
        run(30, 16'd2, 1'b0);

        // Asynchronous reset between clock edges while running.
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check_zero("async_reset");
        model_reset();
        sq = 16'd3;
        repeat (2) @(negedge clk);
        check_zero("reset_held");
        rst = 1'b1;
        run(60, 16'd3, 1'b0);

        // Random speed and direction changes, biased toward small periods.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 7) == 0) sq = 16'($urandom_range(0, 6));
            if ($urandom_range(0, 9) == 0) dir = ~dir;
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
